// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared constants and state encoding for the RV32M sequencer
// Purpose: funct3 codes, FSM states and width defaults used by
//          mdu_regfile_sequencer and mdu_iter_core.
// Ports:   none (package).
package mdu_pkg;

   localparam int MDU_XLEN = 32;
   localparam int MDU_AW   = 5;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_READ = 2'd1,
      S_EXEC = 2'd2,
      S_WB   = 2'd3
   } state_e;

endpackage

// File: rtl/mdu_iter_core.sv
// rtl/mdu_iter_core.sv - iterative unsigned shift-add multiply / restoring divide
// Purpose: one result bit per step on unsigned magnitudes; the caller applies signs.
// Ports:   clk, rst_n (async, active-low); start loads op_a/op_b and count=XLEN-1;
//          step advances one iteration; is_div selects divide; last is count==0;
//          result is {hi,lo} product or {remainder,quotient}.
module mdu_iter_core
   import mdu_pkg::*;
#(
   parameter int XLEN = MDU_XLEN
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              step,
   input  logic              is_div,
   input  logic [XLEN-1:0]   op_a,
   input  logic [XLEN-1:0]   op_b,
   output logic              last,
   output logic [2*XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN);

   // p holds {accumulator, multiplier} for multiply, {remainder, dividend/quotient} for divide.
   logic [2*XLEN-1:0] p_q, p_d;
   logic [XLEN-1:0]   m_q, m_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [XLEN:0]     sum;
   logic [XLEN:0]     sh;
   logic [XLEN+1:0]   diff;

   always_comb begin
      p_d   = p_q;
      m_d   = m_q;
      cnt_d = cnt_q;
      sum   = {1'b0, p_q[2*XLEN-1:XLEN]} + (p_q[0] ? {1'b0, m_q} : '0);
      // Partial remainder shifted left with the next dividend bit brought in.
      sh    = p_q[2*XLEN-1:XLEN-1];
      diff  = {1'b0, sh} - {2'b00, m_q};
      if (start) begin
         p_d   = {{XLEN{1'b0}}, (is_div ? op_a : op_b)};
         m_d   = is_div ? op_b : op_a;
         cnt_d = CW'(XLEN - 1);
      end else if (step) begin
         cnt_d = cnt_q - CW'(1);
         if (is_div) begin
            // diff sign bit set means the trial subtraction underflowed: restore.
            p_d = {(diff[XLEN+1] ? sh[XLEN-1:0] : diff[XLEN-1:0]),
                   p_q[XLEN-2:0], ~diff[XLEN+1]};
         end else begin
            p_d = {sum, p_q[XLEN-1:1]};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_q   <= '0;
         m_q   <= '0;
         cnt_q <= '0;
      end else begin
         p_q   <= p_d;
         m_q   <= m_d;
         cnt_q <= cnt_d;
      end
   end

   assign last   = (cnt_q == '0);
   assign result = p_q;

endmodule

// File: rtl/mdu_regfile_sequencer.sv
// rtl/mdu_regfile_sequencer.sv - multi-cycle RV32M sequencer driving the register-file ports
// Purpose: accepts one M-op, reads rs1/rs2 for one cycle, runs multiply/divide,
//          writes rd for one cycle (never to x0).
// Ports:   req_valid/req_ready/req_funct3/req_rs1/req_rs2/req_rd from decode;
//          rs1/rs2/rs1_rd_en/rs2_rd_en/rS1/rS2 read side; rd/rd_wd_en/rD write side;
//          busy (non-IDLE), done (WB pulse).
// Option:  MDU_FASTMUL_EN selects a single-cycle 33x33 signed multiply.
module mdu_regfile_sequencer
   import mdu_pkg::*;
#(
   parameter int XLEN = MDU_XLEN,
   parameter int AW   = MDU_AW
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [2:0]      req_funct3,
   input  logic [AW-1:0]   req_rs1,
   input  logic [AW-1:0]   req_rs2,
   input  logic [AW-1:0]   req_rd,
   output logic [AW-1:0]   rs1,
   output logic [AW-1:0]   rs2,
   output logic [AW-1:0]   rd,
   output logic            rs1_rd_en,
   output logic            rs2_rd_en,
   output logic            rd_wd_en,
   output logic [XLEN-1:0] rD,
   input  logic [XLEN-1:0] rS1,
   input  logic [XLEN-1:0] rS2,
   output logic            busy,
   output logic            done
);

   localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

   state_e          state_q, state_d;
   logic [2:0]      f3_q, f3_d;
   logic [AW-1:0]   rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
   logic            neg_q, neg_d, spec_q, spec_d;
   logic [XLEN-1:0] sval_q, sval_d;

   logic              a_signed, b_signed, neg1, neg2, is_spec, core_start, core_step, core_last;
   logic [XLEN-1:0]   abs1, abs2, spec_val, div_sel, div_fix, result;
   logic [2*XLEN-1:0] core_res, mul_fix;

`ifdef MDU_FASTMUL_EN
   logic [XLEN-1:0]         opa_q, opa_d, opb_q, opb_d;
   logic                    ea_q, ea_d, eb_q, eb_d;
   logic signed [2*XLEN+1:0] prod;
`endif

   // Operand signedness from the latched funct3.
   assign a_signed = (f3_q == F3_MUL) || (f3_q == F3_MULH) || (f3_q == F3_MULHSU) ||
                     (f3_q == F3_DIV) || (f3_q == F3_REM);
   assign b_signed = (f3_q == F3_MUL) || (f3_q == F3_MULH) ||
                     (f3_q == F3_DIV) || (f3_q == F3_REM);
   assign neg1     = a_signed & rS1[XLEN-1];
   assign neg2     = b_signed & rS2[XLEN-1];
   assign abs1     = neg1 ? -rS1 : rS1;
   assign abs2     = neg2 ? -rS2 : rS2;

   always_comb begin
      is_spec  = 1'b0;
      spec_val = '0;
      if (f3_q[2]) begin
         if (rS2 == '0) begin
            is_spec  = 1'b1;
            spec_val = f3_q[1] ? rS1 : '1;
         end else if (a_signed && rS1 == XMIN && rS2 == '1) begin
            is_spec  = 1'b1;
            spec_val = f3_q[1] ? '0 : XMIN;
         end
      end
   end

   mdu_iter_core #(.XLEN(XLEN)) u_core (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (core_start),
      .step   (core_step),
      .is_div (f3_q[2]),
      .op_a   (abs1),
      .op_b   (abs2),
      .last   (core_last),
      .result (core_res)
   );

   always_comb begin
      mul_fix = neg_q ? -core_res : core_res;
      div_sel = f3_q[1] ? core_res[2*XLEN-1:XLEN] : core_res[XLEN-1:0];
      div_fix = neg_q ? -div_sel : div_sel;
      if (spec_q)               result = sval_q;
      else if (f3_q[2])         result = div_fix;
      else if (f3_q == F3_MUL)  result = mul_fix[XLEN-1:0];
      else                      result = mul_fix[2*XLEN-1:XLEN];
`ifdef MDU_FASTMUL_EN
      prod = $signed({ea_q, opa_q}) * $signed({eb_q, opb_q});
      if (!f3_q[2]) result = (f3_q == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
`endif
   end

   always_comb begin
      state_d    = state_q;
      f3_d       = f3_q;
      rs1_d      = rs1_q;
      rs2_d      = rs2_q;
      rd_d       = rd_q;
      neg_d      = neg_q;
      spec_d     = spec_q;
      sval_d     = sval_q;
      core_start = 1'b0;
      core_step  = 1'b0;
      req_ready  = 1'b0;
      rs1_rd_en  = 1'b0;
      rs2_rd_en  = 1'b0;
      rd_wd_en   = 1'b0;
      rD         = '0;
      done       = 1'b0;
`ifdef MDU_FASTMUL_EN
      opa_d = opa_q;
      opb_d = opb_q;
      ea_d  = ea_q;
      eb_d  = eb_q;
`endif
      case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               f3_d    = req_funct3;
               rs1_d   = req_rs1;
               rs2_d   = req_rs2;
               rd_d    = req_rd;
               state_d = S_READ;
            end
         end
         S_READ: begin
            rs1_rd_en = 1'b1;
            rs2_rd_en = 1'b1;
            // Remainder follows the dividend; everything else takes sign1 ^ sign2.
            neg_d     = (f3_q[2] && f3_q[1]) ? neg1 : (neg1 ^ neg2);
            spec_d    = is_spec;
            sval_d    = spec_val;
            state_d   = is_spec ? S_WB : S_EXEC;
`ifdef MDU_FASTMUL_EN
            opa_d      = rS1;
            opb_d      = rS2;
            ea_d       = neg1;
            eb_d       = neg2;
            core_start = !is_spec && f3_q[2];
`else
            core_start = !is_spec;
`endif
         end
         S_EXEC: begin
            core_step = 1'b1;
`ifdef MDU_FASTMUL_EN
            if (core_last || !f3_q[2]) state_d = S_WB;
`else
            if (core_last) state_d = S_WB;
`endif
         end
         S_WB: begin
            rD       = result;
            done     = 1'b1;
            // The register file does not protect x0.
            rd_wd_en = (rd_q != '0);
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         f3_q    <= '0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         rd_q    <= '0;
         neg_q   <= 1'b0;
         spec_q  <= 1'b0;
         sval_q  <= '0;
`ifdef MDU_FASTMUL_EN
         opa_q   <= '0;
         opb_q   <= '0;
         ea_q    <= 1'b0;
         eb_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         f3_q    <= f3_d;
         rs1_q   <= rs1_d;
         rs2_q   <= rs2_d;
         rd_q    <= rd_d;
         neg_q   <= neg_d;
         spec_q  <= spec_d;
         sval_q  <= sval_d;
`ifdef MDU_FASTMUL_EN
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         ea_q    <= ea_d;
         eb_q    <= eb_d;
`endif
      end
   end

   assign rs1  = rs1_q;
   assign rs2  = rs2_q;
   assign rd   = rd_q;
   assign busy = (state_q != S_IDLE);

endmodule
